gci_std_display_clear_arbiter: RTL and testbench
================================================

GCI_STD_DISPLAY_CLEAR_ARBITER -- requirements
Module: gci_std_display_clear_arbiter

Interface
REQ-001 SHALL have parameter P_CLEAR_ADDR, default 32'h0000C000, the byte address of the Display Clear command.
REQ-002 SHALL have parameter P_BITMAP_BASE, default 32'h0000C400, the byte address of bitmap pixel 0.
REQ-003 SHALL have parameter P_PIXEL_COUNT, default 307200, the number of pixels written per clear.
REQ-004 SHALL have ports, one per line:
- iCLOCK, in, 1, single clock.
- inRESET, in, 1, asynchronous active-low reset.
- iBUS_REQ, in, 1, write request from the bus side; addresses are >= 32'h400 (pre-decoded).
- oBUS_BUSY, out, 1, back-pressure to the bus.
- iBUS_ADDR, in, 32, byte address.
- iBUS_DATA, in, 32, write data.
- oIF_WR_REQ, out, 1, write request to the display controller.
- iIF_WR_BUSY, in, 1, display controller back-pressure.
- oIF_WR_ADDR, out, 32, word address.
- oIF_WR_DATA, out, 32, write data.
- oCLEAR_ACTIVE, out, 1, high while a clear sequence is running.

Function
REQ-005 A bus transfer SHALL be accepted in a cycle with iBUS_REQ=1 and oBUS_BUSY=0.
REQ-006 A downstream transfer SHALL complete in a cycle with oIF_WR_REQ=1 and iIF_WR_BUSY=0.
REQ-007 oBUS_BUSY SHALL equal (state!=IDLE) OR (oIF_WR_REQ AND iIF_WR_BUSY).
REQ-008 The output is a single register stage; while iIF_WR_BUSY=1, oIF_WR_REQ, oIF_WR_ADDR and oIF_WR_DATA SHALL hold stable.
REQ-009 The FSM SHALL have two states, IDLE and CLEAR.
REQ-010 In IDLE, an accepted transfer with iBUS_ADDR!=P_CLEAR_ADDR SHALL, at the next edge, drive oIF_WR_REQ=1, oIF_WR_ADDR={2'b00,iBUS_ADDR[31:2]} and oIF_WR_DATA=iBUS_DATA, giving 1-cycle latency.
REQ-011 In IDLE, an accepted transfer with iBUS_ADDR==P_CLEAR_ADDR SHALL NOT be forwarded. At the next edge it SHALL:
- latch colour iBUS_DATA[15:0];
- clear the 19-bit pixel counter to 0;
- enter CLEAR;
- drive oIF_WR_REQ=1, oIF_WR_ADDR=(P_BITMAP_BASE>>2), oIF_WR_DATA={16'h0,colour}.
REQ-012 In CLEAR, each completed downstream transfer SHALL increment the counter. The next edge SHALL present address (P_BITMAP_BASE>>2)+counter with the same data.
REQ-013 When pixel P_PIXEL_COUNT-1 completes, the next edge SHALL return to IDLE with oIF_WR_REQ=0; the counter SHALL NOT wrap.
REQ-014 In IDLE, when a completion and an acceptance occur in the same cycle, the new transfer SHALL be loaded with no bubble. When a completion occurs with no new acceptance, oIF_WR_REQ SHALL fall to 0.
REQ-015 oCLEAR_ACTIVE SHALL be 1 exactly while state==CLEAR.
REQ-016 Only iBUS_DATA[15:0] is used for the clear colour; bits [31:16] SHALL be ignored.

Reset
REQ-017 On inRESET=0, asynchronously:
- state=IDLE, counter=0, colour=0;
- oIF_WR_REQ=0, oIF_WR_ADDR=0, oIF_WR_DATA=0;
- oCLEAR_ACTIVE=0, oBUS_BUSY=0.
REQ-018 Reset asserted mid-clear SHALL abort the sequence with no further writes issued after release.

Configuration
REQ-019 With GCI_STD_DISPLAY_CLEAR_DONE_EN defined, output port oCLEAR_DONE (1 bit) SHALL exist. It SHALL pulse high for exactly one cycle, the cycle after the last pixel completes, and reset to 0.
REQ-020 Without GCI_STD_DISPLAY_CLEAR_DONE_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-021 A shared package/include SHALL hold the IDLE/CLEAR state encodings and the default address and pixel-count constants.
REQ-022 The block SHALL be flat, with no sub-module. It instances between gci_std_display bus decode and gci_std_display_display_controller.

Verification
REQ-023 Pass-through: write addr 32'h400, data 32'h12345678, with iIF_WR_BUSY=0 -> next cycle oIF_WR_REQ=1, oIF_WR_ADDR=32'h100, oIF_WR_DATA=32'h12345678 for one cycle.
REQ-024 Back-pressure: iIF_WR_BUSY=1 for 5 cycles during a pass-through -> outputs stable, oBUS_BUSY=1 for those cycles, then the write completes once.
REQ-025 Clear: write 32'h0000C000, data 32'hFFFFF800, with P_PIXEL_COUNT=4 -> writes to 32'h3100..32'h3103, each with data 32'h0000F800. oCLEAR_ACTIVE is high throughout, then IDLE; oCLEAR_DONE pulses once when enabled.
REQ-026 Bus write issued during a clear -> held off by oBUS_BUSY until IDLE, then forwarded unchanged.
REQ-027 Reset pulse after pixel 2 of 4 -> all outputs 0 and no further oIF_WR_REQ.
REQ-028 Back-to-back pass-through writes with iIF_WR_BUSY=0 -> one write per cycle, no bubbles.

Source files
------------

// File: rtl/gci_std_display_clear_arbiter_pkg.sv
// ============================================================================
// Module      : gci_std_display_clear_arbiter_pkg
// Description : Shared state encoding and default constants for the display
//               clear arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gci_std_display_clear_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [31:0] C_CLEAR_ADDR  = 32'h0000_C000;
    localparam logic [31:0] C_BITMAP_BASE = 32'h0000_C400;
    localparam int          C_PIXEL_COUNT = 307200;
    localparam int          C_CNT_W       = 19;

endpackage

`default_nettype wire

// File: rtl/gci_std_display_clear_arbiter.sv
// ============================================================================
// Module      : gci_std_display_clear_arbiter
// Description : Forwards bus writes to the display controller and expands a
//               write to the clear address into a full-bitmap colour fill.
//               Optional oCLEAR_DONE port: define GCI_STD_DISPLAY_CLEAR_DONE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gci_std_display_clear_arbiter
    import gci_std_display_clear_arbiter_pkg::*;
#(
    parameter logic [31:0] P_CLEAR_ADDR  = C_CLEAR_ADDR,
    parameter logic [31:0] P_BITMAP_BASE = C_BITMAP_BASE,
    parameter int          P_PIXEL_COUNT = C_PIXEL_COUNT
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iBUS_REQ,
    output logic        oBUS_BUSY,
    input  logic [31:0] iBUS_ADDR,
    input  logic [31:0] iBUS_DATA,
    output logic        oIF_WR_REQ,
    input  logic        iIF_WR_BUSY,
    output logic [31:0] oIF_WR_ADDR,
    output logic [31:0] oIF_WR_DATA,
    output logic        oCLEAR_ACTIVE
`ifdef GCI_STD_DISPLAY_CLEAR_DONE_EN
    ,
    output logic        oCLEAR_DONE
`endif
);

    localparam logic [C_CNT_W-1:0] C_LAST      = C_CNT_W'(P_PIXEL_COUNT - 1);
    localparam logic [31:0]        C_BASE_WORD = P_BITMAP_BASE >> 2;

    state_e               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]          color_q, color_d;
    logic                 wr_req_q, wr_req_d;
    logic [31:0]          wr_addr_q, wr_addr_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic                 done_q, done_d;

    logic                 w_busy;
    logic                 w_accept;
    logic                 w_complete;

    assign w_complete = wr_req_q & ~iIF_WR_BUSY;
    assign w_busy     = (state_q != ST_IDLE) | (wr_req_q & iIF_WR_BUSY);
    assign w_accept   = iBUS_REQ & ~w_busy;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        color_d   = color_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    wr_req_d = 1'b1;
                    if (iBUS_ADDR == P_CLEAR_ADDR) begin
                        state_d   = ST_CLEAR;
                        cnt_d     = '0;
                        color_d   = iBUS_DATA[15:0];
                        wr_addr_d = C_BASE_WORD;
                        wr_data_d = {16'h0000, iBUS_DATA[15:0]};
                    end else begin
                        wr_addr_d = {2'b00, iBUS_ADDR[31:2]};
                        wr_data_d = iBUS_DATA;
                    end
                end else if (w_complete) begin
                    wr_req_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (w_complete) begin
                    if (cnt_q == C_LAST) begin
                        // Counter parks on the last pixel rather than wrapping.
                        state_d  = ST_IDLE;
                        wr_req_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        wr_addr_d = C_BASE_WORD + {{(32-C_CNT_W){1'b0}}, cnt_q + 1'b1};
                        wr_data_d = {16'h0000, color_q};
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            color_q   <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            color_q   <= color_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign oBUS_BUSY     = w_busy;
    assign oIF_WR_REQ    = wr_req_q;
    assign oIF_WR_ADDR   = wr_addr_q;
    assign oIF_WR_DATA   = wr_data_q;
    assign oCLEAR_ACTIVE = (state_q == ST_CLEAR);

`ifdef GCI_STD_DISPLAY_CLEAR_DONE_EN
    assign oCLEAR_DONE = done_q;
`else
    logic w_done_unused;
    assign w_done_unused = done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gci_std_display_clear_arbiter.sv
// ============================================================================
// Module      : tb_gci_std_display_clear_arbiter
// Description : Self-checking bench; a queue of expected downstream writes
//               predicts every output of the clear arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gci_std_display_clear_arbiter;

    localparam int          PIX  = 4;
    localparam logic [31:0] CLR  = 32'h0000_C000;
    localparam logic [31:0] BASE = 32'h0000_C400;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        clr;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_req;
    logic        bus_busy;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;
    logic        if_req;
    logic        if_busy;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        clr_active;
`ifdef GCI_STD_DISPLAY_CLEAR_DONE_EN
    logic        clr_done;
`endif

    wr_t  exp_q[$];
    int   n_clr;
    logic exp_done;
    int   n_checks;
    int   n_fail;

    always #5 clk = ~clk;

    gci_std_display_clear_arbiter #(
        .P_CLEAR_ADDR  (CLR),
        .P_BITMAP_BASE (BASE),
        .P_PIXEL_COUNT (PIX)
    ) u_dut (
        .iCLOCK        (clk),
        .inRESET       (rst_n),
        .iBUS_REQ      (bus_req),
        .oBUS_BUSY     (bus_busy),
        .iBUS_ADDR     (bus_addr),
        .iBUS_DATA     (bus_data),
        .oIF_WR_REQ    (if_req),
        .iIF_WR_BUSY   (if_busy),
        .oIF_WR_ADDR   (if_addr),
        .oIF_WR_DATA   (if_data),
        .oCLEAR_ACTIVE (clr_active)
`ifdef GCI_STD_DISPLAY_CLEAR_DONE_EN
        ,
        .oCLEAR_DONE   (clr_done)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic reset_outputs_zero();
        check("rst_req", {31'b0, if_req}, 32'd0);
        check("rst_addr", if_addr, 32'd0);
        check("rst_data", if_data, 32'd0);
        check("rst_active", {31'b0, clr_active}, 32'd0);
        check("rst_busy", {31'b0, bus_busy}, 32'd0);
`ifdef GCI_STD_DISPLAY_CLEAR_DONE_EN
        check("rst_done", {31'b0, clr_done}, 32'd0);
`endif
    endtask

    // One clock cycle: drive inputs, compare outputs with the queue model,
    // then advance the model by whatever completed and was accepted.
    task automatic cycle(input logic breq, input logic [31:0] a, input logic [31:0] d,
                         input logic ifb);
        logic m_busy;
        logic acc;
        logic cmp;
        wr_t  h;
        bus_req  = breq;
        bus_addr = a;
        bus_data = d;
        if_busy  = ifb;
        #2;
        check("if_req", {31'b0, if_req}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("if_addr", if_addr, exp_q[0].a);
            check("if_data", if_data, exp_q[0].d);
        end
        check("clr_active", {31'b0, clr_active}, {31'b0, n_clr != 0});
        m_busy = (n_clr != 0) || ((exp_q.size() != 0) && ifb);
        check("bus_busy", {31'b0, bus_busy}, {31'b0, m_busy});
`ifdef GCI_STD_DISPLAY_CLEAR_DONE_EN
        check("clr_done", {31'b0, clr_done}, {31'b0, exp_done});
`endif
        acc = breq && !m_busy;
        cmp = (exp_q.size() != 0) && !ifb;
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        if (cmp) begin
            h = exp_q.pop_front();
            if (h.clr) begin
                n_clr--;
                if (n_clr == 0) exp_done = 1'b1;
            end
        end
        if (acc) begin
            if (a == CLR) begin
                for (int i = 0; i < PIX; i++)
                    exp_q.push_back('{a: (BASE >> 2) + 32'(i), d: {16'h0, d[15:0]}, clr: 1'b1});
                n_clr += PIX;
            end else begin
                exp_q.push_back('{a: {2'b00, a[31:2]}, d: d, clr: 1'b0});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_clr    = 0;
        exp_done = 1'b0;
        rst_n    = 1'b0;
        bus_req  = 1'b0;
        bus_addr = '0;
        bus_data = '0;
        if_busy  = 1'b0;
        #12;
        reset_outputs_zero();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pass-through, then 5 cycles of back-pressure.
        cycle(1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0);
        idle(2);
        cycle(1'b1, 32'h0000_0404, 32'hCAFE_0001, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_0408, 32'h0BAD_0BAD, 1'b1);
        idle(3);

        // Clear with busy cycles inside, then a write queued behind it.
        cycle(1'b1, CLR, 32'hFFFF_F800, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < PIX + 3; i++) cycle(1'b1, 32'h0000_0800, 32'hA5A5_5A5A, 1'b0);
        idle(3);

        // Back-to-back writes with no back-pressure.
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'h0000_1000 + 32'(4 * i), 32'h100 + 32'(i), 1'b0);
        idle(2);

        // Reset pulse after two of four pixels.
        cycle(1'b1, CLR, 32'h0000_1234, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs_zero();
        exp_q.delete();
        n_clr    = 0;
        exp_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(8);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? CLR : ($urandom | 32'h0000_0400);
            cycle(($urandom_range(0, 1) == 1), a, $urandom, ($urandom_range(0, 9) < 3));
        end
        idle(PIX + 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
